// File: rtl/pixel_pair_packer.sv
// Purpose : packs a 1-pixel/beat AXI4-Stream video stream into 2-pixel/beat
//           pairs, keeping SOF/EOL framing and flagging framing errors.
// Latency : one cycle from acceptance of the odd pixel (or an EOL even pixel)
//           to m_axis_tvalid. Pulses appear one cycle after the triggering
//           acceptance.
// Backpressure: s_axis_tready = !m_axis_tvalid || m_axis_tready. The output
//           register holds its beat while stalled. With m_axis_tready = 1 the
//           block takes one pixel per clock with no bubbles.
// Ports   : aclk/aresetn (async active-low); s_axis_* pixel input;
//           m_axis_* pair output (low half = even pixel, high half = odd);
//           err_early_eol, err_late_eol, err_sof_misalign, frame_done pulses.
module pixel_pair_packer #(
  parameter int PIXEL_WIDTH  = 24,
  parameter int FRAME_WIDTH  = 10,
  parameter int FRAME_HEIGHT = 10
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [PIXEL_WIDTH-1:0]   s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic [2*PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     err_early_eol,
  output logic                     err_late_eol,
  output logic                     err_sof_misalign,
  output logic                     frame_done
);

  localparam int CW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

  typedef enum logic {ST_EVEN, ST_ODD} state_e;

  state_e                   state_q, state_d;
  logic [PIXEL_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic                     hold_user_q, hold_user_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     out_vld_q, out_vld_d;
  logic [2*PIXEL_WIDTH-1:0] out_data_q, out_data_d;
  logic                     out_user_q, out_user_d;
  logic                     out_last_q, out_last_d;
  logic                     early_q, early_d;
  logic                     late_q, late_d;
  logic                     mis_q, mis_d;
  logic                     done_q, done_d;

  logic                     in_fire;
  logic [CW-1:0]            eff_col;
  logic [RW-1:0]            eff_row;
  logic [RW-1:0]            row_inc;

  // Ready depends only on the output register, never on s_axis_tvalid.
  assign s_axis_tready = !out_vld_q || m_axis_tready;
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  // SOF relocates the current pixel to the origin of the frame.
  assign eff_col = s_axis_tuser ? '0 : col_q;
  assign eff_row = s_axis_tuser ? '0 : row_q;
  assign row_inc = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_user_d = hold_user_q;
    col_d       = col_q;
    row_d       = row_q;
    out_vld_d   = out_vld_q && !m_axis_tready;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
    early_d     = 1'b0;
    late_d      = 1'b0;
    mis_d       = 1'b0;
    done_d      = 1'b0;

    if (in_fire) begin
      // Position tracking.
      if (s_axis_tlast) begin
        early_d = (eff_col != COL_LAST);
        done_d  = (eff_row == ROW_LAST);
        col_d   = '0;
        row_d   = row_inc;
      end else if (eff_col == COL_LAST) begin
        // Missing EOL: realign to the next line, but do not fake a tlast.
        late_d = 1'b1;
        col_d  = '0;
        row_d  = row_inc;
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end

      // Pairing. An SOF arriving in ODD drops the held pixel and restarts
      // the pair with the SOF pixel as the even half.
      if (state_q == ST_EVEN || s_axis_tuser) begin
        mis_d       = (state_q == ST_ODD);
        hold_data_d = s_axis_tdata;
        hold_user_d = s_axis_tuser;
        if (s_axis_tlast) begin
          out_vld_d  = 1'b1;
          out_data_d = {{PIXEL_WIDTH{1'b0}}, s_axis_tdata};
          out_user_d = s_axis_tuser;
          out_last_d = 1'b1;
          state_d    = ST_EVEN;
        end else begin
          state_d = ST_ODD;
        end
      end else begin
        out_vld_d  = 1'b1;
        out_data_d = {s_axis_tdata, hold_data_q};
        out_user_d = hold_user_q;
        out_last_d = s_axis_tlast;
        state_d    = ST_EVEN;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_EVEN;
      hold_data_q <= '0;
      hold_user_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= 1'b0;
      out_last_q  <= 1'b0;
      early_q     <= 1'b0;
      late_q      <= 1'b0;
      mis_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_user_q <= hold_user_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
      early_q     <= early_d;
      late_q      <= late_d;
      mis_q       <= mis_d;
      done_q      <= done_d;
    end
  end

  assign m_axis_tvalid    = out_vld_q;
  assign m_axis_tdata     = out_data_q;
  assign m_axis_tuser     = out_user_q;
  assign m_axis_tlast     = out_last_q;
  assign err_early_eol    = early_q;
  assign err_late_eol     = late_q;
  assign err_sof_misalign = mis_q;
  assign frame_done       = done_q;

endmodule

// File: doc/pixel_pair_packer.md
Name: pixel_pair_packer

Overview:
- Packs a one-pixel-per-beat AXI4-Stream video stream into the two-pixel-per-beat (48-bit pixel-pair) stream consumed by the splicer path.
- Sits upstream of the splicer and is the inverse of pair-to-pixel conversion.
- Preserves SOF (tuser) and EOL (tlast) framing.
- Tracks line and row position and flags framing errors.

Parameters:
- PIXEL_WIDTH, 24, bits per pixel; output beat is 2*PIXEL_WIDTH (48 at default).
- FRAME_WIDTH, 10, pixels per line; must be even.
- FRAME_HEIGHT, 10, lines per frame.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; one clock domain, asynchronous, active-low.
- s_axis_tdata  in  PIXEL_WIDTH  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tuser  in  1  SOF; marks pixel 0 of a frame.
- s_axis_tlast  in  1  EOL; marks the last pixel of a line.
- m_axis_tdata  out  2*PIXEL_WIDTH  pixel pair; [PIXEL_WIDTH-1:0] is the even pixel, the upper half is the odd pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tuser  out  1  SOF of the pair.
- m_axis_tlast  out  1  EOL of the pair.
- err_early_eol  out  1  one-cycle pulse: tlast accepted with col != FRAME_WIDTH-1.
- err_late_eol  out  1  one-cycle pulse: pixel at col FRAME_WIDTH-1 accepted without tlast.
- err_sof_misalign  out  1  one-cycle pulse: tuser accepted on an odd pixel.
- frame_done  out  1  one-cycle pulse: tlast accepted on row FRAME_HEIGHT-1.

Behaviour:
- Reset (async assert, sync release):
  - m_axis_tvalid/tuser/tlast = 0; m_axis_tdata = 0.
  - All pulses = 0.
  - State = EVEN; col = 0; row = 0; held pixel discarded.
  - Reset mid-pair drops the half pair; no partial beat is emitted after release.
- Handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready in both states; combinational from the output register only, independent of s_axis_tvalid.
  - Output register holds tdata/tuser/tlast stable while m_axis_tvalid && !m_axis_tready.
  - m_axis_tvalid clears on m_axis_tready unless a new beat loads in the same cycle.
- State EVEN (input accepted):
  - Store pixel in hold_data with hold_user = tuser; go to ODD.
  - If tlast is also set: emit a padded beat the next cycle, {PIXEL_WIDTH'h0, pixel}, tuser = tuser, tlast = 1; pulse err_early_eol; stay in EVEN.
- State ODD (input accepted):
  - If tuser = 0: load output {pixel, hold_data}, tuser = hold_user, tlast = s_axis_tlast; go to EVEN. m_axis_tvalid rises the cycle after acceptance (latency 1 from the odd pixel).
  - If tuser = 1: discard held pixel; pulse err_sof_misalign; treat the pixel as a new even pixel (hold it, hold_user = 1, col = 0, row = 0); stay in ODD; no output.
- Position counters:
  - On every accepted pixel: col increments; row increments on tlast.
  - tuser forces the pixel to col 0, row 0.
  - tlast: col -> 0. If col != FRAME_WIDTH-1, pulse err_early_eol.
  - col == FRAME_WIDTH-1 without tlast: pulse err_late_eol; col -> 0; row increments; output tlast is not forced.
  - row wraps FRAME_HEIGHT-1 -> 0.
  - frame_done pulses the cycle after the tlast on row FRAME_HEIGHT-1 is accepted.
- Pulse timing: all pulses are registered, exactly one cycle wide, and asserted the cycle after the triggering acceptance.
- Throughput: with m_axis_tready = 1, 1 pixel/clk in and 1 beat every 2 clk out; no bubbles.

Test Plan:
- 10x10 frame, pixel k = 24'h(k), m_axis_tready = 1 -> 50 beats.
  - Beat 0 = {24'h1, 24'h0}, tuser = 1; all other beats tuser = 0.
  - tlast = 1 on beats 4, 9, …, 49.
  - frame_done pulses once, after pixel 99; no error pulses.
- Same frame, m_axis_tready toggling 1,0,0,1 ->
  - s_axis_tready = 0 whenever the output is valid and stalled.
  - m_axis_tdata stable during stalls.
  - Identical 50-beat sequence to the first test.
- tlast on col 4 (even pixel, value 24'hA4) -> beat {24'h0, 24'hA4}, tlast = 1; err_early_eol one pulse; next pixel packs as col 0.
- Line with no tlast on col 9 -> err_late_eol one pulse; output tlast = 0 on that beat; next pixel is col 0 / even half.
- tuser on col 3 after col 2 (24'hC2) held -> err_sof_misalign.
  - 24'hC2 never appears on the output.
  - Next beat = {col-4 pixel, col-3 pixel} with tuser = 1.
- aresetn pulsed low while one pixel is held ->
  - All outputs go to 0 immediately.
  - After release, the first beat is formed only from pixels sent after reset.
